imem_responder: RTL
===================

Name: imem_responder

Overview:
- Memory-side responder for the core's instruction-fetch read interface.
- Accepts single-cycle read strobes with a 20-bit byte address and returns one 32-bit word after a fixed, programmable wait-state latency, signalled by a one-cycle ready pulse.
- Backed by a synchronous word array, preloaded through a side load port by the testbench or boot loader.
- Sits between the fetch stage and instruction memory in the CPU top level.

Parameters:
ADDR_W, 20, byte-address width of the fetch port and the load port.
DEPTH_WORDS, 4096, number of 32-bit words in the backing array.
WAIT_CYCLES, 2, wait states inserted between request acceptance and the response (0 allowed).
FILL_WORD, 32'hE1A00000, data returned for out-of-range reads (ARM NOP, mov r0,r0).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mem_addr  in  ADDR_W  read byte address, sampled when mem_re is accepted
mem_re  in  1  read request strobe, single cycle
mem_rdata  out  32  read data; valid with mem_ready, held until the next response
mem_ready  out  1  one-cycle response pulse
ld_we  in  1  load-port write enable
ld_addr  in  ADDR_W  load-port byte address
ld_wdata  in  32  load-port write data
busy  out  1  high while a request is outstanding
err  out  3  sticky flags: [0] misaligned, [1] out-of-range, [2] overlapping request
err_clr  in  1  clears all err bits

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Reset values: mem_ready=0, mem_rdata=0, busy=0, err=0, state=IDLE, wait counter=0. Array contents are not reset.
- FSM states:
  - IDLE: mem_re=1 at an edge captures mem_addr and loads the counter with WAIT_CYCLES. Next state is WAIT, or RESP directly when WAIT_CYCLES=0.
  - WAIT: counter decrements each edge. At the edge where the counter reaches 0, go to RESP.
  - RESP: mem_ready=1 for exactly one cycle, then return to IDLE.
- Latency: mem_re sampled at edge N → mem_ready is driven high by edge N+1+WAIT_CYCLES and low at the following edge.
- mem_rdata is registered on the edge that raises mem_ready and holds its value until the next response.
- Array read is performed on that same edge.
- Word index = captured addr[ADDR_W-1:2].
  - addr[1:0]≠0: return the aligned word and set err[0].
  - Index ≥ DEPTH_WORDS: return FILL_WORD and set err[1].
- mem_re in WAIT or RESP: ignored, no extra response, err[2] set.
- busy = (state≠IDLE).
- Load port: ld_we writes ld_wdata to word ld_addr[ADDR_W-1:2] at the edge, independent of FSM state.
  - Out-of-range load writes are dropped silently.
  - ld_addr[1:0] is ignored.
- Same-edge collision of a load write and the response read to the same word: old data is returned (read-before-write). A write on any earlier edge is visible.
- err bits are sticky until err_clr. If set and clear occur in the same cycle, set wins.
- Reset mid-request (WAIT or RESP): request is aborted, mem_ready drops immediately, no response is issued after release.

Optional Feature:
- Macro: IMEM_RAND_WAIT_EN.
- Defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset seed 8'hA5, advances every clk.
  - Each accepted request loads the counter with WAIT_CYCLES + lfsr[1:0], giving latency WAIT_CYCLES+1 to WAIT_CYCLES+4.
  - All other rules are unchanged.
- Not defined: no LFSR logic; latency is fixed at WAIT_CYCLES+1.

Test Plan:
- Load word 0=32'hE3A01005, WAIT_CYCLES=2, mem_re pulse with addr 0 at edge N → mem_ready high only in cycle after edge N+3; mem_rdata=32'hE3A01005 and still 32'hE3A01005 ten cycles later; err=0.
- WAIT_CYCLES=0, word 1=32'h12345678, read addr 4 at edge N → mem_ready high in cycle after edge N+1 with 32'h12345678; busy high for exactly 1 cycle.
- Read addr 20'h06 → word 1 returned, err=3'b001. Read addr 20'h10000 (index 16384) → FILL_WORD, err=3'b011. err_clr pulse → err=0.
- Second mem_re 1 cycle after the first → single mem_ready pulse with first address's data, err[2]=1.
- rst_n low during WAIT → mem_ready=0, busy=0 immediately. After release, a new read at addr 8 completes with nominal latency.
- Connect to fetch stage, load words 0/4/8 with 32'hA0000000/32'hA0000001/32'hA0000002 → fetched instruction sequence matches in order, pc advances 0→4→8, no err bits set.

Source files
------------

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Memory-side responder for the instruction-fetch read port.
//               Accepts a single-cycle read strobe and returns one 32-bit word
//               after WAIT_CYCLES wait states, with a one-cycle ready pulse.
//               The backing word array is preloaded through a side load port.
//
// Ports       : clk, rst_n        clock, asynchronous active-low reset
//               mem_addr, mem_re  fetch request (byte address, strobe)
//               mem_rdata         response data, held until the next response
//               mem_ready         one-cycle response pulse
//               ld_we, ld_addr,   load-port word write (ld_addr[1:0] ignored,
//               ld_wdata          out-of-range writes dropped)
//               busy              high while a request is outstanding
//               err, err_clr      sticky flags {overlap, out-of-range,
//                                 misaligned}, cleared by err_clr
//
// Option      : IMEM_RAND_WAIT_EN adds an 8-bit LFSR that stretches each
//               request by 0..3 extra wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder #(
    parameter int          ADDR_W      = 20,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] FILL_WORD   = 32'hE1A00000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_re,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              busy,
    output logic [2:0]        err,
    input  logic              err_clr
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int MEM_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Holds WAIT_CYCLES plus the largest random extension (3).
    localparam int CNT_W = $clog2(WAIT_CYCLES + 5);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return (64'(idx) < 64'(DEPTH_WORDS));
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_load;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [2:0]         w_err_set;
    logic [2:0]         r_err;
    logic               r_ready;
    logic [31:0]        r_rdata;
    logic [31:0]        w_rd_data;
    logic [31:0]        r_mem [DEPTH_WORDS];
    logic               w_ld_unused;

    // Byte offset within a load word carries no meaning.
    assign w_ld_unused = ^ld_addr[1:0];

`ifdef IMEM_RAND_WAIT_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_load = CNT_W'(WAIT_CYCLES) + CNT_W'(r_lfsr[1:0]);
`else
    assign w_load = CNT_W'(WAIT_CYCLES);
`endif

    // ------------------------------------------------------------------
    // Next-state logic. A load value of zero skips WAIT entirely, so the
    // response edge always lands WAIT_CYCLES+1 edges after acceptance.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_err_set   = 3'b000;
        case (r_state)
            ST_IDLE: begin
                if (mem_re) begin
                    w_idx_nxt    = mem_addr[ADDR_W-1:2];
                    w_cnt_nxt    = w_load;
                    w_err_set[0] = |mem_addr[1:0];
                    w_err_set[1] = !in_range(mem_addr[ADDR_W-1:2]);
                    w_state_nxt  = (w_load == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_err_set[2] = mem_re;
                w_cnt_nxt    = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_err_set[2] = mem_re;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Array read happens on the response edge; a load to the same word on
    // that edge lands after the read (old data returned).
    assign w_rd_data = in_range(r_idx) ? r_mem[r_idx[MEM_W-1:0]] : FILL_WORD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
            r_err   <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_ready <= (r_state == ST_RESP);
            if (r_state == ST_RESP) begin
                r_rdata <= w_rd_data;
            end
            // Set takes priority over a simultaneous clear.
            r_err <= (err_clr ? 3'b000 : r_err) | w_err_set;
        end
    end

    // Backing array: no reset, written from the load port in any state.
    always_ff @(posedge clk) begin
        if (ld_we && in_range(ld_addr[ADDR_W-1:2])) begin
            r_mem[ld_addr[MEM_W+1:2]] <= ld_wdata;
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;

endmodule
`default_nettype wire
